jt49_cfg_arb: RTL and testbench

Register-write arbiter and configuration holder for the PSG core. It shares the 16-entry AY register file between two requesters: A, the CPU bus, and B, the playback sequencer. Writes are serialised with a req/ack handshake and aligned to the PSG clock enable. The block drives the configuration consumed by the noise generator (5-bit period), the mixer and the envelope restart.

---
 rtl/jt49_cfg_arb.sv | 120 ++++++++++++
 tb/tb_jt49_cfg_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module   : jt49_cfg_arb
// Brief    : Two-requester register-write arbiter and AY config holder.
// Revision : 1.0
// ============================================================================
module jt49_cfg_arb #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       a_req,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_din,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_din,
  output logic       b_ack,
  output logic       busy,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_dout,
  output logic [4:0] noise_period,
  output logic [7:0] mixer,
  output logic       env_rst
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [3:0] C_NOISE_REG = 4'd6;
  localparam logic [3:0] C_MIXER_REG = 4'd7;
  localparam logic [3:0] C_ENV_REG   = 4'd13;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [7:0] r_regs [16];
  logic [3:0] r_addr;
  logic [7:0] r_din;
  logic       r_win_b;
  logic       r_last_b;
  logic       w_select;
  logic       w_commit;
  logic       w_pick_b;
  logic [7:0] w_wdata;

  // AY register widths; unimplemented bits always read back as zero.
  function automatic logic [7:0] ay_mask(input logic [3:0] addr);
    case (addr)
      4'd1, 4'd3, 4'd5, 4'd13: ay_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: ay_mask = 8'h1F;
      default:                 ay_mask = 8'hFF;
    endcase
  endfunction

  // On a tie B wins only in round-robin mode when A was granted last.
  assign w_pick_b = b_req & (~a_req | (RR & ~r_last_b));
  assign w_wdata  = r_din & ay_mask(r_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cen && (a_req || b_req)) w_next = S_WRITE;
      S_WRITE: if (cen) w_next = S_HOLD;
      S_HOLD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_select = (r_state == S_IDLE) && cen && (a_req || b_req);
    w_commit = (r_state == S_WRITE) && cen;
    busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
      r_addr       <= 4'd0;
      r_din        <= 8'h00;
      r_win_b      <= 1'b0;
      r_last_b     <= 1'b1;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      env_rst      <= 1'b0;
      rd_dout      <= 8'h00;
      noise_period <= 5'd0;
      mixer        <= 8'h00;
    end else begin
      if (w_select) begin
        r_addr   <= w_pick_b ? b_addr : a_addr;
        r_din    <= w_pick_b ? b_din  : a_din;
        r_win_b  <= w_pick_b;
        r_last_b <= w_pick_b;
      end
      a_ack   <= w_commit & ~r_win_b;
      b_ack   <= w_commit &  r_win_b;
      env_rst <= w_commit && (r_addr == C_ENV_REG);
      if (w_commit) begin
        r_regs[r_addr] <= w_wdata;
        if (r_addr == C_NOISE_REG) noise_period <= w_wdata[4:0];
        if (r_addr == C_MIXER_REG) mixer <= w_wdata;
      end
      // Read port sees the pre-write contents on a same-edge collision.
      rd_dout <= r_regs[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt49_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt49_cfg_arb
// Brief    : Scoreboard bench for jt49_cfg_arb (round-robin and fixed priority).
// Revision : 1.0
// ============================================================================
module tb_jt49_cfg_arb;

  typedef struct packed {
    logic       who;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       a_req, b_req;
  logic [3:0] a_addr, b_addr, rd_addr;
  logic [7:0] a_din, b_din;

  logic       a_ack_rr, b_ack_rr, busy_rr, env_rr;
  logic [7:0] rd_rr, mixer_rr;
  logic [4:0] noise_rr;
  logic       a_ack_fp, b_ack_fp, busy_fp, env_fp;
  logic [7:0] rd_fp, mixer_fp;
  logic [4:0] noise_fp;

  logic       fp_mode = 1'b0;
  int         cen_mode = 0;
  int         cnt = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic       prev_ack = 1'b0;

  logic       a_ack_s, b_ack_s, busy_s, env_s;
  logic [7:0] rd_s, mixer_s;
  logic [4:0] noise_s;

  assign a_ack_s = fp_mode ? a_ack_fp : a_ack_rr;
  assign b_ack_s = fp_mode ? b_ack_fp : b_ack_rr;
  assign busy_s  = fp_mode ? busy_fp  : busy_rr;
  assign env_s   = fp_mode ? env_fp   : env_rr;
  assign rd_s    = fp_mode ? rd_fp    : rd_rr;
  assign mixer_s = fp_mode ? mixer_fp : mixer_rr;
  assign noise_s = fp_mode ? noise_fp : noise_rr;

  jt49_cfg_arb #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .cen(cen),
    .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack_rr),
    .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack_rr),
    .busy(busy_rr), .rd_addr(rd_addr), .rd_dout(rd_rr),
    .noise_period(noise_rr), .mixer(mixer_rr), .env_rst(env_rr)
  );

  jt49_cfg_arb #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .cen(cen),
    .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack_fp),
    .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack_fp),
    .busy(busy_fp), .rd_addr(rd_addr), .rd_dout(rd_fp),
    .noise_period(noise_fp), .mixer(mixer_fp), .env_rst(env_fp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ay_width(input logic [3:0] a, input logic [7:0] d);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: ay_width = d & 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: ay_width = d & 8'h1F;
      default:                 ay_width = d;
    endcase
  endfunction

  task automatic expect_wr(input logic who, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.who  = who;
    e.addr = a;
    e.data = ay_width(a, d);
    sb.push_back(e);
  endtask

  // Raise req, wait (bounded) for ack, drop req in the cycle after ack.
  task automatic do_write(input logic who, input logic [3:0] a, input logic [7:0] d,
                          output int lat);
    logic got;
    if (who) begin b_req = 1'b1; b_addr = a; b_din = d; end
    else     begin a_req = 1'b1; a_addr = a; a_din = d; end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = who ? b_ack_s : a_ack_s;
    end
    check(who ? "b_ack_seen" : "a_ack_seen", 32'(got), 32'd1);
    if (who) b_req = 1'b0; else a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    a_req = 1'b0;
    b_req = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy_s),  32'd0);
    check({tag, "_a_ack"}, 32'(a_ack_s), 32'd0);
    check({tag, "_b_ack"}, 32'(b_ack_s), 32'd0);
    check({tag, "_env"},   32'(env_s),   32'd0);
    check({tag, "_rd"},    32'(rd_s),    32'd0);
    check({tag, "_noise"}, 32'(noise_s), 32'd0);
    check({tag, "_mixer"}, 32'(mixer_s), 32'd0);
  endtask

  initial begin
    cen = 1'b1;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = (cnt == 0);
        default: cen = 1'b0;
      endcase
    end
  end

  // Scoreboard: every ack pops one expected write, in grant order.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_ack) begin
        check("ack_width", 32'(a_ack_s | b_ack_s), 32'd0);
        check("env_width", 32'(env_s), 32'd0);
      end
      if (a_ack_s || b_ack_s) begin
        exp_t e;
        check("ack_both", 32'(a_ack_s & b_ack_s), 32'd0);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("grant_who", 32'(b_ack_s), 32'(e.who));
          check("env_rst", 32'(env_s), 32'(e.addr == 4'd13));
          if (e.addr == 4'd7) check("mixer_at_ack", 32'(mixer_s), 32'(e.data));
          if (e.addr == 4'd6) check("noise_at_ack", 32'(noise_s), 32'(e.data[4:0]));
        end
      end
      prev_ack = a_ack_s | b_ack_s;
    end else begin
      prev_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [3:0] addrs [3];
    addrs[0] = 4'd1; addrs[1] = 4'd6; addrs[2] = 4'd13;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    a_addr = 4'd0; b_addr = 4'd0; a_din = 8'h00; b_din = 8'h00; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset_dut();
    check_all_zero("post_reset");

    // Single A write with cen held high
    rd_addr = 4'd6;
    expect_wr(1'b0, 4'd6, 8'hFF);
    do_write(1'b0, 4'd6, 8'hFF, lat);
    check("a_latency", 32'(lat), 32'd2);
    check("noise_period", 32'(noise_s), 32'h1F);
    check("rd_reg6", 32'(rd_s), 32'h1F);
    check("b_ack_idle", 32'(b_ack_s), 32'd0);

    // Masking by B
    for (int i = 0; i < 3; i++) begin
      rd_addr = addrs[i];
      expect_wr(1'b1, addrs[i], 8'hFF);
      do_write(1'b1, addrs[i], 8'hFF, lat);
      check("rd_masked", 32'(rd_s), 32'(ay_width(addrs[i], 8'hFF)));
    end

    // Round-robin contention on the mixer register
    reset_dut();
    rd_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      expect_wr(1'b0, 4'd7, 8'hA0 + 8'(i));
      expect_wr(1'b1, 4'd7, 8'hB0 + 8'(i));
    end
    fork
      begin int l; for (int i = 0; i < 3; i++) do_write(1'b0, 4'd7, 8'hA0 + 8'(i), l); end
      begin int l; for (int i = 0; i < 3; i++) do_write(1'b1, 4'd7, 8'hB0 + 8'(i), l); end
    join
    check("rr_drained", 32'(sb.size()), 32'd0);
    check("rr_mixer_final", 32'(mixer_s), 32'hB2);

    // Fixed-priority contention
    fp_mode = 1'b1;
    reset_dut();
    for (int i = 0; i < 3; i++) expect_wr(1'b0, 4'd7, 8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) expect_wr(1'b1, 4'd7, 8'hB0 + 8'(i));
    fork
      begin int l; for (int i = 0; i < 3; i++) do_write(1'b0, 4'd7, 8'hA0 + 8'(i), l); end
      begin int l; for (int i = 0; i < 3; i++) do_write(1'b1, 4'd7, 8'hB0 + 8'(i), l); end
    join
    check("fp_drained", 32'(sb.size()), 32'd0);
    check("fp_rd_final", 32'(rd_s), 32'hB2);

    // cen one cycle in four
    fp_mode = 1'b0;
    reset_dut();
    @(posedge clk); #1 cen_mode = 1;
    begin
      int g = 0;
      do begin @(negedge clk); #1; g++; end while (cnt != 1 && g < 8);
    end
    expect_wr(1'b0, 4'd7, 8'h38);
    a_req = 1'b1; a_addr = 4'd7; a_din = 8'h38;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("cen_busy", 32'(busy_s), 32'(k >= 4));
      check("cen_ack", 32'(a_ack_s), 32'(k == 8));
      check("cen_mixer", 32'(mixer_s), (k == 8) ? 32'h38 : 32'h0);
    end
    a_req = 1'b0;
    @(posedge clk); #1;
    check("hold_one_clk", 32'(busy_s), 32'd0);
    @(posedge clk); #1 cen_mode = 0;
    repeat (2) @(negedge clk);

    // Reset while a write is parked in WRITE
    #1 a_req = 1'b1; a_addr = 4'd7; a_din = 8'h55;
    @(posedge clk); #1 cen_mode = 2;
    @(negedge clk); #1;
    check("parked_busy", 32'(busy_s), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; cen_mode = 0;
    @(negedge clk);
    expect_wr(1'b0, 4'd7, 8'h55);
    expect_wr(1'b1, 4'd6, 8'h0A);
    fork
      begin int l; do_write(1'b0, 4'd7, 8'h55, l); end
      begin int l; do_write(1'b1, 4'd6, 8'h0A, l); end
    join
    check("post_mixer", 32'(mixer_s), 32'h55);
    check("post_noise", 32'(noise_s), 32'h0A);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
